// File: rtl/dma_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// dma_dispatch_ctrl
//
// Dispatches DMA descriptors, one at a time, from the descriptor FIFO into the
// read-source and write-destination engines. A popped descriptor is captured
// into the eng_* registers and a single eng_start pulse launches both engines.
// The block then waits for both engines to report done (any order, including
// the same cycle) and pulses desc_done, or parks in ERROR on an engine error.
//
// Optional feature macro: DMA_DISPATCH_WATCHDOG_EN
//   Defined   : an ACTIVE-cycle watchdog raises err_code=3 when it reaches
//               csr_timeout-1 (csr_timeout==0 disables it).
//   Undefined : no watchdog; csr_timeout is ignored; err_code never reads 3.
//
// Descriptor handshake: desc_valid means the FIFO holds a descriptor whose
// fields are on desc_*; desc_ready is raised combinationally only in IDLE and
// only while csr_halt is low. A descriptor is consumed (FIFO popped) in the
// cycle where desc_valid && desc_ready; desc_ready never depends on anything
// but desc_valid, csr_halt and the current state.
//
// State is one-hot and exported on the state port for the CSR block:
//   IDLE=00001 LAUNCH=00010 ACTIVE=00100 COMPLETE=01000 ERROR=10000
// -----------------------------------------------------------------------------
module dma_dispatch_ctrl #(
    parameter int ADDR_W   = 64,
    parameter int LENGTH_W = 20,
    parameter int CNT_W    = 32,
    parameter int WDOG_W   = 24
) (
    input  logic                clk,
    input  logic                reset_n,

    // descriptor FIFO side
    input  logic                desc_valid,
    output logic                desc_ready,
    input  logic                desc_go,
    input  logic [1:0]          desc_mode,
    input  logic [ADDR_W-1:0]   desc_src,
    input  logic [ADDR_W-1:0]   desc_dst,
    input  logic [LENGTH_W-1:0] desc_length,

    // read/write engine side
    output logic                eng_start,
    output logic [1:0]          eng_mode,
    output logic [ADDR_W-1:0]   eng_src,
    output logic [ADDR_W-1:0]   eng_dst,
    output logic [LENGTH_W-1:0] eng_length,
    input  logic                rd_done,
    input  logic                wr_done,
    input  logic                rd_err,
    input  logic                wr_err,

    // CSR side
    input  logic                csr_halt,
    input  logic                csr_reset_dispatcher,
    input  logic [WDOG_W-1:0]   csr_timeout,
    output logic                busy,
    output logic                desc_done,
    output logic [CNT_W-1:0]    done_cnt,
    output logic [CNT_W-1:0]    skip_cnt,
    output logic                stopped_on_error,
    output logic [1:0]          err_code,
    output logic [4:0]          state
);

    typedef enum logic [4:0] {
        S_IDLE     = 5'b00001,
        S_LAUNCH   = 5'b00010,
        S_ACTIVE   = 5'b00100,
        S_COMPLETE = 5'b01000,
        S_ERROR    = 5'b10000
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_READ    = 2'd1;
    localparam logic [1:0] ERR_WRITE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    state_t                state_q, state_d;
    logic                  rd_seen_q, rd_seen_d;
    logic                  wr_seen_q, wr_seen_d;
    logic [1:0]            err_code_q, err_code_d;
    logic [CNT_W-1:0]      done_cnt_q, done_cnt_d;
    logic [CNT_W-1:0]      skip_cnt_q, skip_cnt_d;
    logic [1:0]            eng_mode_q, eng_mode_d;
    logic [ADDR_W-1:0]     eng_src_q, eng_src_d;
    logic [ADDR_W-1:0]     eng_dst_q, eng_dst_d;
    logic [LENGTH_W-1:0]   eng_length_q, eng_length_d;

    logic                  timeout_hit;
    logic                  any_err;
    logic                  both_done;

    // An engine error pre-empts a completion seen in the same cycle.
    assign any_err   = rd_err | wr_err;
    // Done pulses landing in the current cycle count together with latched ones.
    assign both_done = (rd_seen_q | rd_done) & (wr_seen_q | wr_done);

`ifdef DMA_DISPATCH_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_q, wdog_d;

    // Watchdog next value: cleared at launch, counts ACTIVE cycles, saturates.
    always_comb begin
        wdog_d = wdog_q;
        if (state_q == S_LAUNCH) begin
            wdog_d = '0;
        end else if ((state_q == S_ACTIVE) && (wdog_q != '1)) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    // Timeout fires on the ACTIVE cycle whose count equals csr_timeout-1.
    assign timeout_hit = (state_q == S_ACTIVE) && (csr_timeout != '0) &&
                         (wdog_q == (csr_timeout - WDOG_W'(1)));
`else
    // Without the watchdog the limit register has no consumer.
    logic wdog_unused;
    assign wdog_unused = ^csr_timeout;
    assign timeout_hit = 1'b0;
`endif

    // State and datapath registers; reset abandons any descriptor in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            rd_seen_q    <= 1'b0;
            wr_seen_q    <= 1'b0;
            err_code_q   <= ERR_NONE;
            done_cnt_q   <= '0;
            skip_cnt_q   <= '0;
            eng_mode_q   <= '0;
            eng_src_q    <= '0;
            eng_dst_q    <= '0;
            eng_length_q <= '0;
        end else begin
            state_q      <= state_d;
            rd_seen_q    <= rd_seen_d;
            wr_seen_q    <= wr_seen_d;
            err_code_q   <= err_code_d;
            done_cnt_q   <= done_cnt_d;
            skip_cnt_q   <= skip_cnt_d;
            eng_mode_q   <= eng_mode_d;
            eng_src_q    <= eng_src_d;
            eng_dst_q    <= eng_dst_d;
            eng_length_q <= eng_length_d;
        end
    end

    // Next-state, datapath next values and per-state pulse outputs.
    always_comb begin
        state_d      = state_q;
        rd_seen_d    = rd_seen_q;
        wr_seen_d    = wr_seen_q;
        err_code_d   = err_code_q;
        done_cnt_d   = done_cnt_q;
        skip_cnt_d   = skip_cnt_q;
        eng_mode_d   = eng_mode_q;
        eng_src_d    = eng_src_q;
        eng_dst_d    = eng_dst_q;
        eng_length_d = eng_length_q;
        desc_ready   = 1'b0;
        eng_start    = 1'b0;
        desc_done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                desc_ready = desc_valid & ~csr_halt;
                if (desc_valid && !csr_halt) begin
                    if (desc_go && (desc_length != '0)) begin
                        eng_mode_d   = desc_mode;
                        eng_src_d    = desc_src;
                        eng_dst_d    = desc_dst;
                        eng_length_d = desc_length;
                        state_d      = S_LAUNCH;
                    end else begin
                        // Popped but not executed: count it and stay idle.
                        skip_cnt_d = skip_cnt_q + CNT_W'(1);
                    end
                end
            end

            S_LAUNCH: begin
                eng_start = 1'b1;
                // Fresh seen flags, but keep a done that races the start pulse.
                rd_seen_d = rd_done;
                wr_seen_d = wr_done;
                if (any_err) begin
                    err_code_d = rd_err ? ERR_READ : ERR_WRITE;
                    state_d    = S_ERROR;
                end else begin
                    state_d = S_ACTIVE;
                end
            end

            S_ACTIVE: begin
                rd_seen_d = rd_seen_q | rd_done;
                wr_seen_d = wr_seen_q | wr_done;
                if (any_err) begin
                    err_code_d = rd_err ? ERR_READ : ERR_WRITE;
                    state_d    = S_ERROR;
                end else if (both_done) begin
                    state_d = S_COMPLETE;
                end else if (timeout_hit) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_ERROR;
                end
            end

            S_COMPLETE: begin
                desc_done  = 1'b1;
                done_cnt_d = done_cnt_q + CNT_W'(1);
                state_d    = S_IDLE;
            end

            S_ERROR: begin
                // Parked until software acknowledges; counters survive.
                if (csr_reset_dispatcher) begin
                    err_code_d = ERR_NONE;
                    rd_seen_d  = 1'b0;
                    wr_seen_d  = 1'b0;
                    state_d    = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign eng_mode         = eng_mode_q;
    assign eng_src          = eng_src_q;
    assign eng_dst          = eng_dst_q;
    assign eng_length       = eng_length_q;
    assign busy             = (state_q != S_IDLE);
    assign stopped_on_error = (state_q == S_ERROR);
    assign done_cnt         = done_cnt_q;
    assign skip_cnt         = skip_cnt_q;
    assign err_code         = err_code_q;
    assign state            = state_q;

endmodule

// File: doc/dma_dispatch_ctrl.md
Name: dma_dispatch_ctrl

Overview:
- Sequences DMA descriptors into the read-source and write-destination engines, one descriptor in flight at a time.
- Pops a descriptor from the descriptor FIFO, registers its fields, and pulses a start to both engines.
- Waits for both engines to report done (in any order) and reports completion, errors and a watchdog timeout to the CSR block.
- Sits between the descriptor FIFO and the read/write FSMs.

Parameters:
- ADDR_W, 64, source/destination address width.
- LENGTH_W, 20, descriptor length width (beats).
- CNT_W, 32, completed-descriptor counter width.
- WDOG_W, 24, watchdog counter and csr_timeout width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; synchronous, active-low.
- desc_valid  in  1  descriptor FIFO not empty.
- desc_ready  out  1  pop descriptor FIFO.
- desc_go  in  1  descriptor go bit.
- desc_mode  in  2  transfer mode.
- desc_src  in  ADDR_W  source address.
- desc_dst  in  ADDR_W  destination address.
- desc_length  in  LENGTH_W  length in beats.
- eng_start  out  1  one-cycle start pulse to both engines.
- eng_mode  out  2  registered mode.
- eng_src  out  ADDR_W  registered source address.
- eng_dst  out  ADDR_W  registered destination address.
- eng_length  out  LENGTH_W  registered length.
- rd_done  in  1  read engine done pulse.
- wr_done  in  1  write engine done pulse.
- rd_err  in  1  read engine error pulse.
- wr_err  in  1  write engine error pulse.
- csr_halt  in  1  stop accepting new descriptors.
- csr_reset_dispatcher  in  1  leave ERROR.
- csr_timeout  in  WDOG_W  watchdog limit; 0 disables it.
- busy  out  1  descriptor in flight.
- desc_done  out  1  one-cycle completion pulse.
- done_cnt  out  CNT_W  completed descriptors.
- skip_cnt  out  CNT_W  skipped descriptors.
- stopped_on_error  out  1  in ERROR.
- err_code  out  2  0 none, 1 read, 2 write, 3 timeout.
- state  out  5  one-hot state, for CSR.

Behaviour:
- Reset values: all outputs 0; state=IDLE (state=5'b00001); rd_seen, wr_seen and watchdog counter cleared. Reset mid-transfer abandons the descriptor with no pulses.
- States (one-hot): IDLE, LAUNCH, ACTIVE, COMPLETE, ERROR.
- IDLE:
  - desc_ready = desc_valid & !csr_halt (combinational, IDLE only).
  - On handshake with desc_go=1 and desc_length!=0: register eng_* fields, go to LAUNCH.
  - On handshake with desc_go=0 or desc_length=0: skip_cnt++, stay in IDLE, no start.
- LAUNCH: eng_start=1 for exactly one cycle; clear rd_seen, wr_seen and watchdog; go to ACTIVE. Latency is handshake at cycle T, eng_start at T+1.
- ACTIVE:
  - rd_seen and wr_seen are sticky on rd_done and wr_done.
  - When (rd_seen|rd_done) & (wr_seen|wr_done), go to COMPLETE. This includes both done pulses in the same cycle.
  - Done pulses arriving during LAUNCH are also latched.
- COMPLETE: desc_done=1 for one cycle; done_cnt++ (wraps at 2^CNT_W); go to IDLE. A done at cycle D gives desc_done at D+1; the earliest next desc_ready is D+2.
- Errors:
  - An error in LAUNCH or ACTIVE goes to ERROR and takes priority over a simultaneous done.
  - err_code: 1 if rd_err, else 2. If rd_err and wr_err arrive together, err_code=1.
  - Errors in IDLE, COMPLETE or ERROR are ignored.
- ERROR:
  - stopped_on_error=1 and busy=1; eng_start=0; desc_ready=0.
  - csr_reset_dispatcher=1 goes to IDLE, clears err_code and seen flags; counters are kept.
  - csr_reset_dispatcher is ignored in all other states.
- busy=1 in LAUNCH, ACTIVE, COMPLETE and ERROR.
- eng_* outputs hold their value until the next accepted descriptor.
- csr_halt asserted mid-transfer lets the current descriptor finish; the block then stays in IDLE.
- Extra done pulses outside ACTIVE/LAUNCH are ignored.

Optional Feature:
- Macro: DMA_DISPATCH_WATCHDOG_EN.
- Defined:
  - The watchdog counter increments each ACTIVE cycle and saturates at all-ones.
  - When csr_timeout!=0 and the counter reaches csr_timeout-1 without completion, go to ERROR with err_code=3.
  - A completion or error in that same cycle wins; the timeout is not flagged.
- Undefined: the watchdog logic is removed; csr_timeout is ignored; err_code never equals 3.

Test Plan:
- Descriptor go=1, length=16, src=0x1000, dst=0x2000; rd_done at +20, wr_done at +35 -> eng_start one cycle after pop; desc_done one cycle after wr_done; done_cnt=1; busy 0 after.
- rd_done and wr_done in the same cycle -> desc_done next cycle; exactly one increment of done_cnt.
- Descriptor with length=0, then one with go=0 -> both popped; skip_cnt=2; no eng_start; done_cnt unchanged.
- wr_err together with rd_done in ACTIVE -> ERROR, err_code=2, stopped_on_error=1, no desc_done; FIFO not popped; csr_reset_dispatcher -> IDLE, err_code=0.
- csr_halt raised mid-transfer with 3 descriptors queued -> current transfer completes; desc_ready stays 0 until halt drops; then the next descriptor is popped.
- Macro defined, csr_timeout=100, no done pulses -> ERROR with err_code=3 after 100 ACTIVE cycles. With csr_timeout=0, or macro undefined -> remains in ACTIVE indefinitely.
